// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter with bounded bursts in front of the data memory.
// Grants are combinational; responses are registered one cycle after the grant.
module dmem_arbiter #(
  parameter int unsigned MEM_LINES = 4096,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_we,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_we,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [31:0] LINE_LIMIT = 32'(MEM_LINES);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  owner_t        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic burst_full;
  logic oor0, oor1;

  assign burst_full = (cnt_q >= BURST_MAX);
  assign oor0 = ({2'b00, m0_addr[31:2]} >= LINE_LIMIT);
  assign oor1 = ({2'b00, m1_addr[31:2]} >= LINE_LIMIT);

  // Under contention the owner keeps the port until its burst is used up.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (!burst_full) begin
          m0_gnt = (owner_q == OWN_M0);
          m1_gnt = (owner_q == OWN_M1);
        end else begin
          m0_gnt = (owner_q == OWN_M1);
          m1_gnt = (owner_q == OWN_M0);
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    daddr  = '0;
    dwdata = '0;
    dwe    = '0;
    if (m0_gnt) begin
      daddr  = m0_addr;
      dwdata = m0_wdata;
      dwe    = oor0 ? 4'b0000 : m0_we;
    end else if (m1_gnt) begin
      daddr  = m1_addr;
      dwdata = m1_wdata;
      dwe    = oor1 ? 4'b0000 : m1_we;
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (m0_gnt || m1_gnt) begin
      if ((m0_gnt && owner_q == OWN_M0) || (m1_gnt && owner_q == OWN_M1)) begin
        cnt_d = burst_full ? cnt_q : cnt_q + CW'(1);
      end else begin
        owner_d = m0_gnt ? OWN_M0 : OWN_M1;
        cnt_d   = CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_M0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // rdata/err hold between responses; drdata is the pre-write line content.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt;
      m1_rvalid <= m1_gnt;
      if (m0_gnt) begin
        m0_err   <= oor0;
        m0_rdata <= oor0 ? '0 : drdata;
      end
      if (m1_gnt) begin
        m1_err   <= oor1;
        m1_rdata <= oor1 ? '0 : drdata;
      end
    end
  end

endmodule
